// File: rtl/load_store_unit_if.sv
// Request, load-result and data-memory signals of the load/store unit.
// master: pipeline plus memory side; slave: the load_store_unit itself.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        misaligned;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_MemWrite;
    logic        mem_MemRead;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        input  stall, ld_valid, ld_data, misaligned, mem_address, mem_write_data,
               mem_MemWrite, mem_MemRead
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
        output stall, ld_valid, ld_data, misaligned, mem_address, mem_write_data,
               mem_MemWrite, mem_MemRead
    );
endinterface

// File: rtl/load_store_unit.sv
// Big-endian MIPS load/store unit on a word-only memory; sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module load_store_unit (
    input  logic             clk,
    input  logic             reset,
    load_store_unit_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] MERGE = 1'b1;

    logic [0:0]  state_reg, state_next;
    logic [31:0] merge_word_reg, merge_word_next;
    logic [29:0] addr_reg;
    logic        ld_valid_reg;
    logic [31:0] ld_data_reg, ld_data_next;
    logic        misaligned_reg;

    logic        is_word, is_half, misalign_now, accept, sub_store;
    logic [31:0] eff_addr;
    logic [1:0]  off;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign is_word = bus.req_size[1];
    assign is_half = (bus.req_size == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_now = bus.req_valid && (state_reg == IDLE) &&
                          ((is_half && bus.req_addr[0]) || (is_word && (bus.req_addr[1:0] != 2'b00)));
    assign eff_addr     = bus.req_addr;
`else
    assign misalign_now = 1'b0;
    always_comb begin
        eff_addr = bus.req_addr;
        if (is_half)
            eff_addr[0] = 1'b0;
        else if (is_word)
            eff_addr[1:0] = 2'b00;
    end
`endif

    assign accept    = bus.req_valid && (state_reg == IDLE) && !misalign_now && !reset;
    assign sub_store = accept && bus.req_write && !is_word;
    assign off       = eff_addr[1:0];

    // Lane gi covers bits [31-8*gi -: 8]; lane 0 is the lowest byte address.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int         HI   = 31 - 8 * gi;
            localparam logic [1:0] LANE = 2'(gi);
            logic       hit;
            logic [7:0] src;
            assign hit = is_word ? 1'b0 : (is_half ? (off[1] == LANE[1]) : (off == LANE));
            assign src = (is_half && !LANE[0]) ? bus.req_wdata[15:8] : bus.req_wdata[7:0];
            assign merge_word_next[HI -: 8] = hit ? src : bus.mem_read_data[HI -: 8];
        end
    endgenerate

    always_comb begin
        case (off)
            2'd0:    rd_byte = bus.mem_read_data[31:24];
            2'd1:    rd_byte = bus.mem_read_data[23:16];
            2'd2:    rd_byte = bus.mem_read_data[15:8];
            default: rd_byte = bus.mem_read_data[7:0];
        endcase
        rd_half = off[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];
        case (bus.req_size)
            2'b00:   ld_data_next = bus.req_unsigned ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   ld_data_next = bus.req_unsigned ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: ld_data_next = bus.mem_read_data;
        endcase
    end

    // Memory strobes are gated by reset so a reset arriving in MERGE drops the pending write.
    always_comb begin
        bus.mem_MemRead    = 1'b0;
        bus.mem_MemWrite   = 1'b0;
        bus.mem_address    = 32'b0;
        bus.mem_write_data = 32'b0;
        bus.stall          = sub_store;
        state_next         = state_reg;
        if (reset) begin
            state_next = IDLE;
        end else if (state_reg == MERGE) begin
            bus.mem_MemWrite   = 1'b1;
            bus.mem_address    = {addr_reg, 2'b00};
            bus.mem_write_data = merge_word_reg;
            state_next         = IDLE;
        end else if (accept) begin
            bus.mem_address = {eff_addr[31:2], 2'b00};
            if (bus.req_write && is_word) begin
                bus.mem_MemWrite   = 1'b1;
                bus.mem_write_data = bus.req_wdata;
            end else begin
                bus.mem_MemRead = 1'b1;
                if (sub_store)
                    state_next = MERGE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            merge_word_reg <= 32'b0;
            addr_reg       <= 30'b0;
            ld_valid_reg   <= 1'b0;
            ld_data_reg    <= 32'b0;
            misaligned_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ld_valid_reg   <= accept && !bus.req_write;
            misaligned_reg <= misalign_now;
            if (accept && !bus.req_write)
                ld_data_reg <= ld_data_next;
            if (sub_store) begin
                merge_word_reg <= merge_word_next;
                addr_reg       <= eff_addr[31:2];
            end
        end
    end

    assign bus.ld_valid   = ld_valid_reg;
    assign bus.ld_data    = ld_data_reg;
    assign bus.misaligned = misaligned_reg;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random checks of load_store_unit against a byte-array memory model.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Word memory seen by the DUT; preload port is used only while the DUT is not writing.
    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = 6'd0;
    logic [31:0] pl_val = 32'd0;

    assign bus.mem_read_data = mem[bus.mem_address[7:2]];

    always @(posedge clk) begin
        if (bus.mem_MemWrite)
            mem[bus.mem_address[7:2]] <= bus.mem_write_data;
        else if (pl_en)
            mem[pl_idx] <= pl_val;
    end

    // Reference: byte-addressed memory, big-endian.
    logic [7:0] ref_bytes [256];

    function automatic logic [31:0] model_word(input int a);
        int base;
        base = a - (a % 4);
        return {ref_bytes[base], ref_bytes[base + 1], ref_bytes[base + 2], ref_bytes[base + 3]};
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz >= 2) ? 4 : ((sz == 1) ? 2 : 1);
    endfunction

    function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input logic u);
        longint v;
        int     n;
        n = nbytes(sz);
        v = 0;
        for (int i = 0; i < n; i++)
            v = v * 256 + longint'(ref_bytes[a + i]);
        if (n < 4 && !u && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic model_store(input int a, input logic [1:0] sz, input logic [31:0] wd);
        int n;
        n = nbytes(sz);
        for (int i = 0; i < n; i++)
            ref_bytes[a + i] = 8'((wd >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = 6'(idx);
        pl_val = val;
        for (int i = 0; i < 4; i++)
            ref_bytes[idx * 4 + i] = val[31 - 8 * i -: 8];
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'($urandom_range(0, 1));
        bus.req_size     = 2'($urandom_range(0, 3));
        bus.req_unsigned = 1'($urandom_range(0, 1));
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;
        #1;
        $display("[TB] idle");
        check("idle_rd",    32'(bus.mem_MemRead),  32'd0);
        check("idle_wr",    32'(bus.mem_MemWrite), 32'd0);
        check("idle_addr",  bus.mem_address,       32'd0);
        check("idle_wdata", bus.mem_write_data,    32'd0);
        check("idle_stall", 32'(bus.stall),        32'd0);
        @(posedge clk);
        #1;
        check("idle_ldv", 32'(bus.ld_valid),   32'd0);
        check("idle_mis", 32'(bus.misaligned), 32'd0);
    endtask

    task automatic req(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
        int          ea;
        logic        mis;
        logic        sub;
        logic [31:0] exp_ld;
        logic [31:0] exp_word;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
        ea  = int'(a);
        mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`ifndef LSU_MISALIGN_TRAP_EN
        if (sz == 2'b01) ea = ea - (ea % 2);
        else if (sz[1])  ea = ea - (ea % 4);
        mis = 1'b0;
`endif
        sub = w && !sz[1];
        $display("[TB] %s size=%0d uns=%0d addr=%h wdata=%h", w ? "store" : "load", sz, u, a, wd);
        #1;
        if (mis) begin
            check("mis_rd",    32'(bus.mem_MemRead),  32'd0);
            check("mis_wr",    32'(bus.mem_MemWrite), 32'd0);
            check("mis_stall", 32'(bus.stall),        32'd0);
        end else begin
            check("req_stall", 32'(bus.stall),        32'(sub));
            check("req_rd",    32'(bus.mem_MemRead),  32'(!w || sub));
            check("req_wr",    32'(bus.mem_MemWrite), 32'(w && !sub));
            check("req_addr",  bus.mem_address,       32'(ea - (ea % 4)));
            if (w && !sub)
                check("sw_wdata", bus.mem_write_data, wd);
        end
        exp_ld = model_load(ea, sz, u);
        @(posedge clk);
        #1;
        check("misaligned", 32'(bus.misaligned), 32'(mis));
        check("ld_valid",   32'(bus.ld_valid),   32'(!mis && !w));
        if (!mis && !w)
            check("ld_data", bus.ld_data, exp_ld);
        if (!mis && w) begin
            model_store(ea, sz, wd);
            exp_word = model_word(ea);
            if (sub) begin
                @(negedge clk);
                #1;
                check("merge_wr",    32'(bus.mem_MemWrite), 32'd1);
                check("merge_rd",    32'(bus.mem_MemRead),  32'd0);
                check("merge_stall", 32'(bus.stall),        32'd0);
                check("merge_addr",  bus.mem_address,       32'(ea - (ea % 4)));
                check("merge_wdata", bus.mem_write_data,    exp_word);
                @(posedge clk);
                #1;
                check("merge_ldv", 32'(bus.ld_valid), 32'd0);
            end
            check("mem_word", mem[ea / 4], exp_word);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;

        for (int i = 0; i < 64; i++)
            preload(i, $urandom);

        #1;
        check("rst_stall", 32'(bus.stall),        32'd0);
        check("rst_ldv",   32'(bus.ld_valid),     32'd0);
        check("rst_ldd",   bus.ld_data,           32'd0);
        check("rst_mis",   32'(bus.misaligned),   32'd0);
        check("rst_rd",    32'(bus.mem_MemRead),  32'd0);
        check("rst_wr",    32'(bus.mem_MemWrite), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors on word 0x10 = 0x80FF7F01.
        preload(4, 32'h80FF7F01);
        req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
        check("lb_const", bus.ld_data, 32'hFFFFFF80);
        req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
        check("lbu_const", bus.ld_data, 32'h00000080);
        req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        check("lh_const", bus.ld_data, 32'h00007F01);
        req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB);
        check("sb_const", mem[4], 32'h80AB7F01);
        req(1'b1, 2'b01, 1'b0, 32'h10, 32'h00001234);
        check("sh_const", mem[4], 32'h12347F01);
        req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        check("lw_const", bus.ld_data, 32'h12347F01);
        req(1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF);
        check("sw_const", mem[5], 32'hDEADBEEF);
        req(1'b1, 2'b01, 1'b0, 32'h13, 32'h00005555);
        req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifndef LSU_MISALIGN_TRAP_EN
        check("lw_forced_align", bus.ld_data, model_word(16));
`endif

        // Reset during MERGE drops the pending byte store.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h000000CD;
        $display("[TB] store size=0 addr=00000010 wdata=000000cd reset-in-merge");
        #1;
        check("rm_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rm_wr", 32'(bus.mem_MemWrite), 32'd0);
        check("rm_rd", 32'(bus.mem_MemRead),  32'd0);
        @(negedge clk);
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        #1;
        check("rm_out_stall", 32'(bus.stall),        32'd0);
        check("rm_out_ldv",   32'(bus.ld_valid),     32'd0);
        check("rm_out_ldd",   bus.ld_data,           32'd0);
        check("rm_out_mis",   32'(bus.misaligned),   32'd0);
        check("rm_out_rd",    32'(bus.mem_MemRead),  32'd0);
        check("rm_out_wr",    32'(bus.mem_MemWrite), 32'd0);
        check("rm_out_addr",  bus.mem_address,       32'd0);
        check("rm_out_wdata", bus.mem_write_data,    32'd0);
        check("rm_mem",       mem[4],                model_word(16));
        req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

        // Random traffic over the first 256 bytes.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0)
                idle_cycle();
            else
                req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    32'($urandom_range(0, 255)), $urandom);
        end

        for (int i = 0; i < 64; i++)
            check("final_mem", mem[i], model_word(i * 4));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
